// File: rtl/mult_share_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mult_share_pkg;

    localparam int unsigned A_W      = 28;
    localparam int unsigned B_W      = 32;
    localparam int unsigned Y_W      = 60;
    // Tag id is sized for the largest supported requester count (16).
    localparam int unsigned ID_W_MAX = 4;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_share_arb_if.sv
// Requester, multiplier and response signals of the shared multiplier.
interface mult_share_arb_if #(
    parameter int unsigned NREQ = 4
);
    import mult_share_pkg::*;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_last;
    logic [NREQ*A_W-1:0] req_a;
    logic [NREQ*B_W-1:0] req_b;
    logic [NREQ-1:0]     req_ready;
    logic [A_W-1:0]      mult_a;
    logic [B_W-1:0]      mult_b;
    logic [Y_W-1:0]      mult_y;
    logic [NREQ-1:0]     rsp_valid;
    logic [Y_W-1:0]      rsp_y;
    logic                busy;

    // Requesters plus external multiplier.
    modport master (
        output req_valid, req_last, req_a, req_b, mult_y,
        input  req_ready, mult_a, mult_b, rsp_valid, rsp_y, busy
    );

    // The arbiter.
    modport slave (
        input  req_valid, req_last, req_a, req_b, mult_y,
        output req_ready, mult_a, mult_b, rsp_valid, rsp_y, busy
    );

endinterface

// File: rtl/mult_share_arb_rr_pick.sv
// Rotating priority encoder: first set request at or above i_ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_id,
    output logic                    o_any
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0] w_idx;

    // Scan from the pointer upward and keep the first hit.
    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IDW'((32'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_id         = w_idx;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one signed 28x32 multiplier, with locked
// bursts and owner tracking through the multiplier latency.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MULT_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    mult_share_arb_if.slave  bus
);
    localparam int unsigned IDW = $clog2(NREQ);

    state_t          r_state;
    state_t          w_next_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_owner;
    logic [NREQ-1:0] w_pick_gnt;
    logic [IDW-1:0]  w_pick_id;
    logic            w_pick_any;
    logic [NREQ-1:0] w_ready;
    logic            w_accept;
    logic [IDW-1:0]  w_acc_id;
    logic            w_acc_last;
    logic [IDW-1:0]  w_ptr_inc;
    logic [A_W-1:0]  r_mult_a;
    logic [B_W-1:0]  r_mult_b;
    tag_t            r_tag [0:MULT_LAT];
    logic [NREQ-1:0] w_rsp_valid;
    logic            w_busy;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_id  (w_pick_id),
        .o_any (w_pick_any)
    );

    // Grant selection: owner when locked, rotating pick otherwise.
    always_comb begin
        w_ready  = '0;
        w_accept = 1'b0;
        w_acc_id = w_pick_id;
        if (r_state == LOCKED) begin
            w_ready[r_owner] = 1'b1;
            w_accept         = bus.req_valid[r_owner];
            w_acc_id         = r_owner;
        end else begin
            w_ready  = w_pick_gnt;
            w_accept = w_pick_any;
        end
        w_acc_last = bus.req_last[w_acc_id];
        w_ptr_inc  = (32'(w_acc_id) == NREQ - 1) ? '0 : w_acc_id + 1'b1;
    end

    // Next-state logic for the lock.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_acc_last) w_next_state = LOCKED;
            LOCKED:  if (w_accept &&  w_acc_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // Lock owner and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            if (!w_acc_last) r_owner  <= w_acc_id;
            else             r_rr_ptr <= w_ptr_inc;
        end
    end

    // Operand capture; operands hold when nothing is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mult_a <= '0;
            r_mult_b <= '0;
        end else if (w_accept) begin
            r_mult_a <= bus.req_a[A_W*w_acc_id +: A_W];
            r_mult_b <= bus.req_b[B_W*w_acc_id +: B_W];
        end
    end

    // Owner tag pipeline tracking the multiplier latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s <= MULT_LAT; s++) r_tag[s] <= '0;
        end else begin
            r_tag[0].valid <= w_accept;
            r_tag[0].id    <= ID_W_MAX'(w_acc_id);
            for (int unsigned s = 1; s <= MULT_LAT; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    // Response decode and busy flag.
    always_comb begin
        w_rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            w_rsp_valid[i] = r_tag[MULT_LAT].valid && (r_tag[MULT_LAT].id == ID_W_MAX'(i));
        w_busy = (r_state == LOCKED);
        for (int unsigned s = 0; s <= MULT_LAT; s++) w_busy = w_busy | r_tag[s].valid;
    end

    assign bus.req_ready = w_ready;
    assign bus.mult_a    = r_mult_a;
    assign bus.mult_b    = r_mult_b;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_y     = bus.mult_y;
    assign bus.busy      = w_busy;

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb with a behavioural arbiter model.
module tb_mult_share_arb;
    import mult_share_pkg::*;

    localparam int NREQ     = 4;
    localparam int MULT_LAT = 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    mult_share_arb_if #(.NREQ(NREQ)) bus ();

    mult_share_arb #(.NREQ(NREQ), .MULT_LAT(MULT_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // External one-cycle signed multiplier.
    always @(posedge clk)
        bus.mult_y <= $signed({{32{bus.mult_a[27]}}, bus.mult_a}) *
                      $signed({{28{bus.mult_b[31]}}, bus.mult_b});

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [27:0] opa [NREQ];
    logic [31:0] opb [NREQ];

    // Model: lock flag/owner, rotating pointer, queue of expected results.
    int m_locked = 0;
    int m_owner  = 0;
    int m_rr     = 0;

    typedef struct {
        int          due;
        int          id;
        logic [59:0] y;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 28'($urandom);
            opb[i] = $urandom;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_locked = 0;
        m_owner  = 0;
        m_rr     = 0;
    endtask

    // One clock: drive at negedge, check grant, clock, check responses.
    task automatic cycle(input logic [3:0] v, input logic [3:0] l);
        int          gid;
        logic [3:0]  eg;
        logic [3:0]  erv;
        logic [59:0] ey;
        logic        eb;
        exp_t        e;
        bus.req_valid = v;
        bus.req_last  = l;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[28*i +: 28] = opa[i];
            bus.req_b[32*i +: 32] = opb[i];
        end
        #1;
        gid = -1;
        if (m_locked != 0) gid = m_owner;
        else
            for (int k = 0; k < NREQ; k++)
                if (gid < 0 && v[(m_rr + k) % NREQ]) gid = (m_rr + k) % NREQ;
        eg = (gid >= 0) ? 4'(1 << gid) : 4'b0000;
        chk("req_ready", 64'(bus.req_ready), 64'(eg));
        if (gid >= 0 && v[gid]) begin
            e.due = cyc + 1 + MULT_LAT;
            e.id  = gid;
            e.y   = 60'(longint'($signed(opa[gid])) * longint'($signed(opb[gid])));
            q.push_back(e);
            if (l[gid]) begin
                m_locked = 0;
                m_rr     = (gid + 1) % NREQ;
            end else begin
                m_locked = 1;
                m_owner  = gid;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        eb  = (m_locked != 0) || (q.size() > 0);
        erv = '0;
        ey  = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e        = q.pop_front();
            erv[e.id] = 1'b1;
            ey       = e.y;
        end
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(erv));
        chk("busy", 64'(bus.busy), 64'(eb));
        if (erv != 4'b0000) chk("rsp_y", 64'(bus.rsp_y), 64'(ey));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(4'b0000, 4'b0000);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end

        // Power-on reset.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset mult_a", 64'(bus.mult_a), 64'd0);
        chk("reset mult_b", 64'(bus.mult_b), 64'd0);
        chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset req_ready", 64'(bus.req_ready), 64'd0);
        reset_n = 1'b1;
        model_reset();

        // Round-robin fairness: all valid, single beats.
        repeat (8) begin
            rand_ops();
            cycle(4'b1111, 4'b1111);
        end
        idle(2);

        // Single beat from requester 2, then pointer lands on 3.
        opa[2] = -28'sd3;
        opb[2] = 32'd100000;
        cycle(4'b0100, 4'b1111);
        idle(2);
        rand_ops();
        cycle(4'b1111, 4'b1111);
        idle(2);

        // Locked burst on requester 1 while 0 and 3 wait.
        rand_ops();
        cycle(4'b0010, 4'b0000);
        rand_ops();
        cycle(4'b1011, 4'b0000);
        rand_ops();
        cycle(4'b1011, 4'b0010);
        rand_ops();
        cycle(4'b1001, 4'b1111);
        rand_ops();
        cycle(4'b0001, 4'b1111);
        idle(2);

        // Bubbles while owner 0 drops valid and requester 1 waits.
        rand_ops();
        cycle(4'b0001, 4'b0000);
        cycle(4'b0010, 4'b1111);
        cycle(4'b0010, 4'b1111);
        cycle(4'b0001, 4'b0001);
        idle(2);

        // Operand extremes.
        opa[0] = 28'h8000000;
        opb[0] = 32'h80000000;
        cycle(4'b0001, 4'b1111);
        opa[1] = 28'h7FFFFFF;
        opb[1] = 32'h80000000;
        cycle(4'b0010, 4'b1111);
        idle(2);

        // Reset one cycle after an accept inside a locked burst.
        rand_ops();
        cycle(4'b0100, 4'b0000);
        rand_ops();
        cycle(4'b0100, 4'b0000);
        reset_n = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("midreset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midreset busy", 64'(bus.busy), 64'd0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("midreset held rsp_valid", 64'(bus.rsp_valid), 64'd0);
        reset_n = 1'b1;
        rand_ops();
        cycle(4'b1111, 4'b1111);
        idle(3);

        // Random traffic, mostly terminating bursts.
        repeat (300) begin
            rand_ops();
            cycle(4'($urandom), ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom));
        end
        bus.req_valid = '0;
        for (int n = 0; n < 40 && m_locked != 0; n++) cycle(4'hF, 4'hF);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
